// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter feeding the 32-entry register bank; one registered write per grant.
// REGARB_ROUND_ROBIN_EN selects round-robin tie-breaking; when undefined, requester 0 wins ties.
module regfile_write_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            r0_valid,
  input  logic [AW-1:0]   r0_addr,
  input  logic [DW-1:0]   r0_data,
  output logic            r0_ready,
  input  logic            r1_valid,
  input  logic [AW-1:0]   r1_addr,
  input  logic [DW-1:0]   r1_data,
  output logic            r1_ready,
  input  logic            hold,
  output logic [NREG-1:0] wr_en,
  output logic [DW-1:0]   wr_data,
  output logic            last_grant,
  output logic [7:0]      stall_cnt
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_reg;
  logic [NREG-1:0] wr_en_reg;
  logic [DW-1:0]   wr_data_reg;
  logic            last_grant_reg;
  logic [7:0]      stall_cnt_reg;

  logic            grant;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_data;
  logic [NREG-1:0] wr_en_next;
  logic            stall;

  // Ready is purely combinational so a hold or a new request acts in the same cycle.
  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (!hold) begin
      if (r0_valid && r1_valid) begin
`ifdef REGARB_ROUND_ROBIN_EN
        if (last_grant_reg) r0_ready = 1'b1;
        else                r1_ready = 1'b1;
`else
        r0_ready = 1'b1;
`endif
      end else if (r0_valid) begin
        r0_ready = 1'b1;
      end else if (r1_valid) begin
        r1_ready = 1'b1;
      end
    end
  end

  assign grant      = r0_ready | r1_ready;
  assign grant_addr = r1_ready ? r1_addr : r0_addr;
  assign grant_data = r1_ready ? r1_data : r0_data;
  assign stall      = (r0_valid & ~r0_ready) | (r1_valid & ~r1_ready);

  // Register 0 is hardwired to zero, so its enable is never driven.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
    if (gi == 0) begin : g_zero
      assign wr_en_next[gi] = 1'b0;
    end else begin : g_reg
      assign wr_en_next[gi] = (grant_addr == AW'(gi));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      wr_en_reg   <= '0;
      wr_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            state_reg   <= WRITE;
            wr_en_reg   <= wr_en_next;
            wr_data_reg <= grant_data;
          end
        end
        WRITE: begin
          if (grant) begin
            wr_en_reg   <= wr_en_next;
            wr_data_reg <= grant_data;
          end else begin
            state_reg <= IDLE;
            wr_en_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          wr_en_reg <= '0;
        end
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      stall_cnt_reg  <= '0;
    end else begin
      if (grant) last_grant_reg <= r1_ready;
      if (stall && stall_cnt_reg != 8'hFF) stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_data    = wr_data_reg;
  assign last_grant = last_grant_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected register writes, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        r0_valid, r1_valid, hold;
  logic [4:0]  r0_addr, r1_addr;
  logic [31:0] r0_data, r1_data;
  logic        r0_ready, r1_ready;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic        last_grant;
  logic [7:0]  stall_cnt;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic rr_build;

  regfile_write_arbiter #(.NREG(32), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .hold(hold), .wr_en(wr_en), .wr_data(wr_data),
    .last_grant(last_grant), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every visible write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_en !== 32'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual_en=%h actual_data=%h required=no_write", wr_en, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_en !== mon_e.en || wr_data !== mon_e.data) begin
          failures++;
          $display("FAIL write actual_en=%h actual_data=%h required_en=%h required_data=%h",
                   wr_en, wr_data, mon_e.en, mon_e.data);
        end else begin
          $display("write en=%h data=%h ok", wr_en, wr_data);
        end
      end
    end
  end

  // Called at posedge+1 with inputs set; checks readies, records the expected write, advances a cycle.
  task automatic grant_cycle(input string tag, input logic e0, input logic e1, input logic push_en);
    exp_t e;
    #1;
    chk({tag, "_r0_ready"}, {31'd0, r0_ready}, {31'd0, e0});
    chk({tag, "_r1_ready"}, {31'd0, r1_ready}, {31'd0, e1});
    if (push_en && e0 && r0_addr != 5'd0) begin
      e.en = 32'd1 << r0_addr; e.data = r0_data; exp_q.push_back(e);
    end
    if (push_en && e1 && r1_addr != 5'd0) begin
      e.en = 32'd1 << r1_addr; e.data = r1_data; exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    r0_valid = 1'b0; r0_addr = 5'd0; r0_data = 32'h0;
    r1_valid = 1'b0; r1_addr = 5'd0; r1_data = 32'h0;
    hold = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    chk("rst_wr_en", wr_en, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_last_grant", {31'd0, last_grant}, 32'd1);
    chk("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
`ifdef REGARB_ROUND_ROBIN_EN
    rr_build = 1'b1;
`else
    rr_build = 1'b0;
`endif
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    do_reset();

    // Single r0 write to register 5, then idle: wr_data must hold.
    r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'h0000_0020;
    grant_cycle("t1", 1'b1, 1'b0, 1'b1);
    clear_inputs();
    @(posedge clk); #1;
    chk("t1_idle_wr_en", wr_en, 32'h0);
    chk("t1_idle_wr_data", wr_data, 32'h0000_0020);
    chk("t1_last_grant", {31'd0, last_grant}, 32'd0);

    // Both valid for 4 cycles.
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'h0000_0333;
    r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h0000_0777;
    for (int i = 0; i < 4; i++) begin
      if (rr_build) grant_cycle("t2", (i % 2) == 0, (i % 2) == 1, 1'b1);
      else          grant_cycle("t2", 1'b1, 1'b0, 1'b1);
    end
    clear_inputs();
    chk("t2_stall_cnt", {24'd0, stall_cnt}, 32'd4);
    chk("t2_last_grant", {31'd0, last_grant}, rr_build ? 32'd1 : 32'd0);
    @(posedge clk); #1;

    // Write to register 0 is accepted but never enables anything.
    r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'hFFFF_FFFF;
    grant_cycle("t3", 1'b0, 1'b1, 1'b1);
    clear_inputs();
    chk("t3_wr_en_zero", wr_en, 32'h0);
    @(posedge clk); #1;
    chk("t3_wr_en_after", wr_en, 32'h0);

    // Hold for 3 cycles, then release in the same cycle.
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd12; r0_data = 32'h0000_000C;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) grant_cycle("t4_hold", 1'b0, 1'b0, 1'b1);
    chk("t4_stall_cnt", {24'd0, stall_cnt}, 32'd3);
    hold = 1'b0;
    grant_cycle("t4_release", 1'b1, 1'b0, 1'b1);
    clear_inputs();
    chk("t4_stall_cnt_after", {24'd0, stall_cnt}, 32'd3);
    @(posedge clk); #1;

    // Saturation of the stall counter.
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd4; r0_data = 32'h0000_0044; hold = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    chk("t5_stall_cnt_254", {24'd0, stall_cnt}, 32'd254);
    repeat (46) @(posedge clk);
    #1;
    chk("t5_stall_cnt_sat", {24'd0, stall_cnt}, 32'd255);
    clear_inputs();
    @(posedge clk); #1;

    // Grant r1 to register 9, then reset before the write can land.
    do_reset();
    r1_valid = 1'b1; r1_addr = 5'd9; r1_data = 32'h0000_0099; hold = 1'b1;
    grant_cycle("t6_hold", 1'b0, 1'b0, 1'b0);
    hold = 1'b0;
    grant_cycle("t6_grant", 1'b0, 1'b1, 1'b0);
    clear_inputs();
    chk("t6_wr_en_pending", wr_en, 32'h0000_0200);
    chk("t6_stall_pre", {24'd0, stall_cnt}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_wr_en_reset", wr_en, 32'h0);
    chk("t6_stall_reset", {24'd0, stall_cnt}, 32'd0);
    chk("t6_last_grant_reset", {31'd0, last_grant}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_wr_en_final", wr_en, 32'h0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
